// File: rtl/regfile_port_master_if.sv
// Command and response handshake bundle for the register file port master.
// The master modport is the block's side; slave is the sequencer/consumer side.
interface regfile_port_master_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W-1:0] cmd_len;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_last;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_wdata, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_last
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_wdata, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_last
    );
endinterface

// File: rtl/regfile_port_master.sv
// Initiator for a single-port register file: single writes and wrapping read bursts,
// with read beats streamed out through one registered valid/ready response stage.
module regfile_port_master #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    regfile_port_master_if.master bus,
    output logic                  wr_done,
    output logic                  busy,
    output logic                  rf_we,
    output logic [ADDR_W-1:0]     rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata,
    output logic [ADDR_W-1:0]     rf_raddr,
    input  logic [DATA_W-1:0]     rf_rdata
);
    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_last_q, rsp_last_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

    logic cmd_accept;
    logic capture;

    assign cmd_accept = bus.cmd_valid && (state_q == IDLE);
    // A beat is only captured when the output slot is free or draining this edge,
    // so a pending beat is never overwritten.
    assign capture    = (state_q == READ) && (!rsp_valid_q || bus.rsp_ready);

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        we_d        = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_last_d  = rsp_last_q;
        rsp_data_d  = rsp_data_q;

        case (state_q)
            IDLE: begin
                if (cmd_accept) begin
                    if (bus.cmd_write) begin
                        state_d = WRITE;
                        we_d    = 1'b1;
                        waddr_d = bus.cmd_addr;
                        wdata_d = bus.cmd_wdata;
                    end else begin
                        state_d = READ;
                        base_d  = bus.cmd_addr;
                        len_d   = bus.cmd_len;
                        cnt_d   = '0;
                    end
                end
            end
            WRITE: state_d = IDLE;
            READ: begin
                if (capture) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == len_q) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (capture) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = rf_rdata;
            rsp_last_d  = (cnt_q == len_q);
        end else if (rsp_valid_q && bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            base_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_last_q  <= rsp_last_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_last  = rsp_last_q;
    assign busy          = (state_q != IDLE);
    assign rf_we         = we_q;
    assign wr_done       = we_q;
    assign rf_waddr      = waddr_q;
    assign rf_wdata      = wdata_q;
    // Address arithmetic is ADDR_W wide, so bursts wrap past the top entry to 0.
    assign rf_raddr      = base_q + cnt_q;
endmodule

// File: tb/tb_regfile_port_master.sv
// Self-checking bench for regfile_port_master: a behavioural register file, a reference
// copy of its contents, and a scoreboard of expected read beats checked by a monitor.
module tb_regfile_port_master;
    localparam int DW = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          load_mem = 1'b1;
    logic          wr_done, busy, rf_we;
    logic [AW-1:0] rf_waddr, rf_raddr;
    logic [DW-1:0] rf_wdata, rf_rdata;

    logic [DW-1:0] mem     [0:15];
    logic [DW-1:0] ref_mem [0:15];
    logic [DW:0]   exp_q   [$];

    int errors = 0;
    int checks = 0;

    regfile_port_master_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    regfile_port_master #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .wr_done  (wr_done),
        .busy     (busy),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .rf_raddr (rf_raddr),
        .rf_rdata (rf_rdata)
    );

    initial forever #5 clk = ~clk;

    // Behavioural register file with combinational read
    initial forever begin
        @(posedge clk);
        if (load_mem) begin
            for (int i = 0; i < 16; i++) mem[i] <= 16'h0100 + 16'(i);
        end else if (rf_we) begin
            mem[rf_waddr] <= rf_wdata;
        end
    end
    assign rf_rdata = mem[rf_raddr];

    // Response monitor: scoreboard compare on handshake, hold check while stalled
    initial begin
        logic          prev_stall;
        logic [DW-1:0] prev_data;
        logic          prev_last;
        logic [DW:0]   e;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    checks++;
                    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== prev_data || bus.rsp_last !== prev_last) begin
                        errors++;
                        $display("FAIL stall_hold: valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                                 bus.rsp_valid, bus.rsp_data, bus.rsp_last, prev_data, prev_last);
                    end
                end
                if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_beat: data=%h last=%b, required no beat", bus.rsp_data, bus.rsp_last);
                    end else begin
                        e = exp_q.pop_front();
                        if ({bus.rsp_last, bus.rsp_data} !== e) begin
                            errors++;
                            $display("FAIL beat: data=%h last=%b, required data=%h last=%b",
                                     bus.rsp_data, bus.rsp_last, e[DW-1:0], e[DW]);
                        end else begin
                            $display("beat data=%h last=%b", bus.rsp_data, bus.rsp_last);
                        end
                    end
                end
                prev_stall = (bus.rsp_valid === 1'b1) && (bus.rsp_ready !== 1'b1);
                prev_data  = bus.rsp_data;
                prev_last  = bus.rsp_last;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_read(input logic [AW-1:0] addr, input logic [AW-1:0] len);
        logic [AW-1:0] a;
        for (int i = 0; i <= int'(len); i++) begin
            a = addr + AW'(i);
            exp_q.push_back({(i == int'(len)), ref_mem[a]});
        end
    endtask

    task automatic send_cmd(input logic w, input logic [AW-1:0] addr, input logic [AW-1:0] len,
                            input logic [DW-1:0] wdata);
        int n;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = addr;
        bus.cmd_len   = len;
        bus.cmd_wdata = wdata;
        if (w) ref_mem[addr] = wdata;
        else   push_read(addr, len);
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.cmd_ready === 1'b1) break;
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL cmd_accept_timeout: cmd_ready=%b, required 1", bus.cmd_ready);
                break;
            end
        end
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = $urandom_range(0, 15);
        bus.cmd_len   = $urandom_range(0, 15);
        bus.cmd_wdata = 16'($urandom);
        $display("cmd write=%b addr=%0d len=%0d wdata=%h", w, addr, len, wdata);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0 && bus.rsp_valid !== 1'b1) break;
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL %s_drain_timeout: pending=%0d rsp_valid=%b, required 0 and 0", name, exp_q.size(), bus.rsp_valid);
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        reset    = 1'b0;
        load_mem = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.cmd_ready, bus.rsp_valid, busy, rf_we, wr_done} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_ctrl: ready,valid,busy,we,done=%b, required 10000",
                     {bus.cmd_ready, bus.rsp_valid, busy, rf_we, wr_done});
        end
        checks++;
        if (bus.rsp_data !== 16'h0 || rf_raddr !== 4'h0 || rf_waddr !== 4'h0 || rf_wdata !== 16'h0) begin
            errors++;
            $display("FAIL reset_data: rsp_data=%h raddr=%h waddr=%h wdata=%h, required all 0",
                     bus.rsp_data, rf_raddr, rf_waddr, rf_wdata);
        end
    endtask

    task automatic test_write();
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 4'd3;
        bus.cmd_wdata = 16'h1234;
        ref_mem[3]    = 16'h1234;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        $display("cmd write=1 addr=3 wdata=1234");
        @(negedge clk);
        checks++;
        if (rf_we !== 1'b1 || wr_done !== 1'b1 || rf_waddr !== 4'd3 || rf_wdata !== 16'h1234) begin
            errors++;
            $display("FAIL write_port: we=%b done=%b waddr=%0d wdata=%h, required 1 1 3 1234",
                     rf_we, wr_done, rf_waddr, rf_wdata);
        end
        checks++;
        if (bus.cmd_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL write_busy: cmd_ready=%b busy=%b, required 0 1", bus.cmd_ready, busy);
        end
        @(negedge clk);
        checks++;
        if (rf_we !== 1'b0 || wr_done !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL write_end: we=%b done=%b cmd_ready=%b, required 0 0 1", rf_we, wr_done, bus.cmd_ready);
        end
        checks++;
        if (mem[3] !== 16'h1234) begin
            errors++;
            $display("FAIL write_mem: mem[3]=%h, required 1234", mem[3]);
        end
    endtask

    task automatic test_burst();
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 4'd5;
        bus.cmd_len   = 4'd3;
        push_read(4'd5, 4'd3);
        @(negedge clk);
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL burst_ready: cmd_ready=%b, required 1", bus.cmd_ready);
        end
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        $display("cmd write=0 addr=5 len=3");
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL burst_latency: rsp_valid=%b at T+1, required 0", bus.rsp_valid);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_last !== (k == 3)) begin
                errors++;
                $display("FAIL burst_beat%0d: valid=%b last=%b, required 1 %b", k, bus.rsp_valid, bus.rsp_last, (k == 3));
            end
        end
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL burst_end: valid=%b busy=%b, required 0 0", bus.rsp_valid, busy);
        end
        wait_drain("burst");
    endtask

    task automatic test_wrap();
        bus.rsp_ready = 1'b1;
        send_cmd(1'b0, 4'd14, 4'd3, 16'h0);
        wait_drain("wrap");
    endtask

    task automatic test_stall();
        logic [3:0] pat;
        int c;
        pat = 4'b1001;
        bus.rsp_ready = 1'b1;
        send_cmd(1'b0, 4'd0, 4'd2, 16'h0);
        c = 0;
        forever begin
            @(posedge clk); #1;
            bus.rsp_ready = pat[c % 4];
            @(negedge clk);
            if (exp_q.size() == 0 && bus.rsp_valid !== 1'b1) break;
            c++;
            if (c > 100) begin
                checks++;
                errors++;
                $display("FAIL stall_timeout: pending=%0d, required 0", exp_q.size());
                break;
            end
        end
        bus.rsp_ready = 1'b1;
    endtask

    task automatic test_pending();
        bus.rsp_ready = 1'b0;
        send_cmd(1'b0, 4'd10, 4'd0, 16'h0);
        send_cmd(1'b1, 4'd9, 4'd0, 16'hBEEF);
        send_cmd(1'b0, 4'd9, 4'd0, 16'h0);
        repeat (4) @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'h010A || bus.rsp_last !== 1'b1) begin
            errors++;
            $display("FAIL pending_beat: valid=%b data=%h last=%b, required 1 010a 1",
                     bus.rsp_valid, bus.rsp_data, bus.rsp_last);
        end
        checks++;
        if (busy !== 1'b1 || exp_q.size() != 2) begin
            errors++;
            $display("FAIL pending_wait: busy=%b pending=%0d, required 1 2", busy, exp_q.size());
        end
        checks++;
        if (mem[9] !== 16'hBEEF) begin
            errors++;
            $display("FAIL pending_write: mem[9]=%h, required beef", mem[9]);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        wait_drain("pending");
    endtask

    task automatic test_reset_mid();
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 4'd0;
        bus.cmd_len   = 4'd7;
        push_read(4'd0, 4'd7);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        $display("cmd write=0 addr=0 len=7");
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.rsp_valid, busy, bus.cmd_ready, rf_we} !== 4'b0010) begin
            errors++;
            $display("FAIL reset_mid: valid,busy,ready,we=%b, required 0010",
                     {bus.rsp_valid, busy, bus.cmd_ready, rf_we});
        end
        checks++;
        if (exp_q.size() != 7) begin
            errors++;
            $display("FAIL reset_mid_beats: pending=%0d, required 7", exp_q.size());
        end
        exp_q.delete();
        send_cmd(1'b0, 4'd4, 4'd1, 16'h0);
        wait_drain("after_reset");
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ref_mem[i] = 16'h0100 + 16'(i);
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b0;

        test_reset();
        test_write();
        test_burst();
        test_wrap();
        test_stall();
        test_pending();
        test_reset_mid();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: pending=%0d, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
